lcd_write_arbiter: RTL and testbench
====================================

Name: lcd_write_arbiter

Overview:
- Owns the HD44780-style character LCD bus: LCD_EN, LCD_RS and LCD_DATA.
- After power-up it runs the fixed init sequence 0x38, 0x0C, 0x06, 0x01.
- It then shares the LCD between two requesters using round-robin arbitration. Examples: the FP ALU result formatter and the status/banner writer.
- Each accepted byte gets setup, enable-pulse and execution-wait timing, so requesters never count delays themselves.

Parameters:
- T_PWR, 750000: power-up wait in clocks before the first init byte (15 ms at 50 MHz).
- T_SETUP, 4: clocks that RS/DATA are stable with EN=0 before EN rises.
- T_EN, 25: clocks EN is held high.
- T_EXEC, 2000: clocks of post-EN wait for normal commands and data (40 us).
- T_LONG, 82000: post-EN wait for clear/home commands (1.64 ms).

Ports:
- Clk50Mhz  in  1  system clock, 50 MHz.
- RstN  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_rs  in  1  0 = command, 1 = character data.
- req0_data  in  8  byte to write.
- req0_ready  out  1  one-cycle accept pulse for requester 0.
- req1_valid  in  1  requester 1 has a byte.
- req1_rs  in  1  as for requester 0.
- req1_data  in  8  as for requester 0.
- req1_ready  out  1  one-cycle accept pulse for requester 1.
- init_done  out  1  high once the init sequence has completed; stays high until reset.
- busy  out  1  high whenever the FSM is not in ARB.
- LCD_EN  out  1  LCD enable strobe.
- LCD_RS  out  1  LCD register select.
- LCD_DATA  out  8  LCD data bus.

Behaviour:
- Reset (RstN=0, asynchronous):
  - Outputs: LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, req*_ready=0, init_done=0, busy=1.
  - Internal state: FSM=PWR_WAIT, counter=0, init index=0, RR pointer=0.
  - Reset mid-transfer aborts immediately and restarts the power-up wait; no partial EN pulse survives.
- FSM states: PWR_WAIT, INIT_LOAD, SETUP, EN_HI, WAIT, ARB.
- PWR_WAIT: counts T_PWR clocks, then goes to INIT_LOAD.
- INIT_LOAD:
  - Latches RS=0 and the init ROM entry at the current index into the output registers.
  - Increments the index, then goes to SETUP.
- SETUP: EN=0 for T_SETUP clocks, then goes to EN_HI.
- EN_HI: EN=1 for T_EN clocks; RS and DATA stay unchanged throughout. Then goes to WAIT.
- WAIT: EN=0 with RS/DATA held.
  - Wait length is T_LONG when the latched RS=0 and DATA is 0x01, 0x02 or 0x03; otherwise T_EXEC.
  - On expiry, if init is not complete: go to INIT_LOAD, or after the 4th entry set init_done=1 and go to ARB.
  - On expiry, if init is complete: go to ARB.
- ARB, grant rule:
  - No requester valid: stay in ARB with busy=0.
  - Exactly one valid: grant it.
  - Both valid: grant the requester the pointer names.
- ARB, on grant:
  - Drive req<g>_ready=1 for exactly that cycle and latch its rs/data.
  - Set the pointer to the other requester; go to SETUP.
- Valid requests are ignored (ready stays 0) until init_done=1.
- Requester obligations:
  - Hold valid, rs and data stable until ready is seen.
  - Deassert valid or present the next byte on the cycle after ready.
- Latency: accept in cycle k, then SETUP covers k+1..k+T_SETUP and EN is high on k+T_SETUP+1..k+T_SETUP+T_EN.
- Throughput: the next accept is no earlier than 1+T_SETUP+T_EN+T_wait clocks after the previous one.
- Counter rules:
  - One shared down-counter, width $clog2(max(T_PWR,T_LONG)+1).
  - Loaded with (T-1) on state entry; the state exits when the counter reaches 0.
  - Every parameter must be ≥1.
- Simultaneous events: a requester deasserting valid in the same cycle the grant would occur gets no grant; this is legal only before ready.
- LCD is write-only: no R/W pin and no busy-flag polling. Timing is purely counter-based.

Decomposition:
- lcd_pkg holds:
  - Init ROM constants: LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY_INC=8'h06, LCD_CLEAR=8'h01.
  - LCD_LINE1=8'h80 and LCD_LINE2=8'hC0.
  - The FSM state enum.
  - Function is_long_cmd(rs, data).
- Sub-module lcd_rr_arbiter2 contains the pointer register and combinational grant from two valids. It takes an advance input from the FSM.

Test Plan:
Every scenario uses T_PWR=10, T_SETUP=2, T_EN=3, T_EXEC=5, T_LONG=12.
1. Release reset with no requests. Required response:
   - EN pulses exactly 4 times with DATA 0x38, 0x0C, 0x06, 0x01, all with RS=0.
   - The wait after 0x01 is 12 clocks; the others are 5.
   - The first EN rise is at cycle 10+1+2+1 after reset release.
   - init_done rises after the last wait.
2. req0 valid with rs=1, data=0x46 from reset. Required response:
   - No ready before init_done.
   - Then ready0 pulses for one cycle, EN is high for 3 cycles with RS=1 and DATA=0x46, and busy=1 throughout.
3. req0 and req1 both continuously valid after init. Required response:
   - Grants alternate 0,1,0,1.
   - Accept-to-accept spacing is 1+2+3+5=11 clocks.
4. Single write of req1 rs=0, data=0x01 after init. Required response: a 12-clock wait; a following write of rs=1, data=0x01 gets a 5-clock wait.
5. Assert RstN=0 during EN_HI of a user write. Required response:
   - LCD_EN=0 and LCD_DATA=0 in the same cycle.
   - init_done=0.
   - On release, the full power-up and init sequence repeats.
6. req0 valid raised, then dropped before ARB is reached (device still in WAIT). Required response: no ready0 and no EN pulse.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and command helpers for the character-LCD write arbiter.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_LINE1     = 8'h80;
  localparam logic [7:0] LCD_LINE2     = 8'hC0;

  localparam int unsigned InitLen = 4;

  typedef enum logic [2:0] {
    StPwrWait,
    StInitLoad,
    StSetup,
    StEnHi,
    StWait,
    StArb
  } lcd_state_e;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] rom;
    unique case (idx)
      2'd0:    rom = LCD_FUNC_SET;
      2'd1:    rom = LCD_DISP_ON;
      2'd2:    rom = LCD_ENTRY_INC;
      default: rom = LCD_CLEAR;
    endcase
    return rom;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves past the winner on advance.
module lcd_rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Granting requester 0 points at 1 next, and vice versa.
  assign ptr_d = (advance_i && (grant_o != 2'b00)) ? grant_o[0] : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// HD44780 bus owner: power-up init sequence, then round-robin sharing between two byte writers
// with all setup/enable/execution timing generated here.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWR   = 750000,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_LONG  = 82000
) (
  input  logic       Clk50Mhz,
  input  logic       RstN,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       init_done,
  output logic       busy,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA
);

  localparam int unsigned TMax = (T_PWR > T_LONG) ? T_PWR : T_LONG;
  localparam int unsigned CntW = $clog2(TMax + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t PwrLast   = cnt_t'(T_PWR - 1);
  localparam cnt_t SetupLast = cnt_t'(T_SETUP - 1);
  localparam cnt_t EnLast    = cnt_t'(T_EN - 1);
  localparam cnt_t ExecLast  = cnt_t'(T_EXEC - 1);
  localparam cnt_t LongLast  = cnt_t'(T_LONG - 1);

  lcd_state_e state_q;
  cnt_t       cnt_q;
  logic [2:0] idx_q;
  logic       en_q;
  logic       rs_q;
  logic [7:0] data_q;
  logic       init_done_q;

  logic       in_arb;
  logic [1:0] grant;

  assign in_arb = (state_q == StArb);

  lcd_rr_arbiter2 u_rr (
    .clk_i     (Clk50Mhz),
    .rst_ni    (RstN),
    .valid_i   ({req1_valid, req0_valid} & {2{in_arb}}),
    .advance_i (in_arb),
    .grant_o   (grant)
  );

  always_ff @(posedge Clk50Mhz or negedge RstN) begin
    if (!RstN) begin
      state_q     <= StPwrWait;
      cnt_q       <= '0;
      idx_q       <= '0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        // Counts up from the reset value of 0 so the power-up wait needs no preload.
        StPwrWait: begin
          if (cnt_q == PwrLast) begin
            cnt_q   <= '0;
            state_q <= StInitLoad;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StInitLoad: begin
          rs_q    <= 1'b0;
          data_q  <= init_rom(idx_q[1:0]);
          idx_q   <= idx_q + 3'd1;
          cnt_q   <= SetupLast;
          state_q <= StSetup;
        end
        StSetup: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b1;
            cnt_q   <= EnLast;
            state_q <= StEnHi;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StEnHi: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b0;
            cnt_q   <= is_long_cmd(rs_q, data_q) ? LongLast : ExecLast;
            state_q <= StWait;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            if (init_done_q) begin
              state_q <= StArb;
            end else if (idx_q == 3'(InitLen)) begin
              init_done_q <= 1'b1;
              state_q     <= StArb;
            end else begin
              state_q <= StInitLoad;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StArb: begin
          if (grant != 2'b00) begin
            rs_q    <= grant[1] ? req1_rs : req0_rs;
            data_q  <= grant[1] ? req1_data : req0_data;
            cnt_q   <= SetupLast;
            state_q <= StSetup;
          end
        end
        default: state_q <= StPwrWait;
      endcase
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign init_done  = init_done_q;
  assign busy       = !in_arb;
  assign LCD_EN     = en_q;
  assign LCD_RS     = rs_q;
  assign LCD_DATA   = data_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench: stimulus queues expected LCD writes and grants, a negedge monitor checks them.
module tb_lcd_write_arbiter;
  import lcd_pkg::*;

  localparam int unsigned T_PWR   = 10;
  localparam int unsigned T_SETUP = 2;
  localparam int unsigned T_EN    = 3;
  localparam int unsigned T_EXEC  = 5;
  localparam int unsigned T_LONG  = 12;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wait_len;
  } lcd_exp_t;

  typedef struct {
    int id;
    int spacing;  // 0 = not checked
  } gnt_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_rs, req1_valid, req1_rs;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, init_done, busy, lcd_en, lcd_rs;
  logic [7:0] lcd_data;

  int checks = 0;
  int failures = 0;

  lcd_exp_t lcd_q[$];
  gnt_exp_t gnt_q[$];

  int npos = 0;
  bit first_chk = 0;
  int tot_rise = 0;
  int tot_rdy = 0;

  always #5 clk = ~clk;

  lcd_write_arbiter #(
    .T_PWR   (T_PWR),
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN),
    .T_EXEC  (T_EXEC),
    .T_LONG  (T_LONG)
  ) dut (
    .Clk50Mhz   (clk),
    .RstN       (rst_n),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .init_done  (init_done),
    .busy       (busy),
    .LCD_EN     (lcd_en),
    .LCD_RS     (lcd_rs),
    .LCD_DATA   (lcd_data)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Posedges since reset release; the release period itself is cycle 1, so cycle N == npos+1.
  always @(posedge clk) begin
    if (!rst_n) npos = 0;
    else npos = npos + 1;
  end

  // Monitor
  bit         prev_en, prev_rdy, prev_done, wait_pend;
  int         rise_c, fall_c, last_acc, pulses, meas;
  lcd_exp_t   cur;
  gnt_exp_t   g;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 0; prev_rdy = 0; prev_done = 0; wait_pend = 0; pulses = 0;
    end else begin
      if (req0_ready || req1_ready) begin
        tot_rdy++;
        chk("ready_both", int'(req0_ready && req1_ready), 0);
        chk("ready_width", int'(prev_rdy), 0);
        chk("ready_before_init", int'(init_done), 1);
        if (gnt_q.size() == 0) begin
          chk("unexpected_ready", 1, 0);
        end else begin
          g = gnt_q.pop_front();
          chk("grant_id", req1_ready ? 1 : 0, g.id);
          if (g.spacing != 0) chk("accept_spacing", npos - last_acc, g.spacing);
        end
        last_acc = npos;
      end
      prev_rdy = req0_ready || req1_ready;

      if (lcd_en && !prev_en) begin
        tot_rise++;
        pulses++;
        if (wait_pend) begin
          meas = npos - fall_c - 1 - int'(T_SETUP);
          chk("wait_len", meas, cur.wait_len);
          wait_pend = 0;
        end
        if (first_chk) begin
          chk("first_en_rise", npos, int'(T_PWR + 1 + T_SETUP));
          first_chk = 0;
        end
        if (lcd_q.size() == 0) begin
          chk("unexpected_en", 1, 0);
          cur = '{rs: lcd_rs, data: lcd_data, wait_len: 0};
        end else begin
          cur = lcd_q.pop_front();
          chk("lcd_rs", int'(lcd_rs), int'(cur.rs));
          chk("lcd_data", int'(lcd_data), int'(cur.data));
        end
        chk("busy_in_en", int'(busy), 1);
        rise_c = npos;
      end

      if (!lcd_en && prev_en) begin
        chk("en_len", npos - rise_c, int'(T_EN));
        chk("rs_stable", int'(lcd_rs), int'(cur.rs));
        chk("data_stable", int'(lcd_data), int'(cur.data));
        chk("busy_in_wait", int'(busy), 1);
        fall_c = npos;
        wait_pend = 1;
      end

      if (wait_pend && !busy) begin
        chk("wait_len", npos - fall_c, cur.wait_len);
        wait_pend = 0;
      end

      if (init_done && !prev_done) begin
        chk("init_pulses", pulses, 4);
        chk("busy_at_init_done", int'(busy), 0);
      end
      prev_en = lcd_en;
      prev_done = init_done;
    end
  end

  task automatic push_init();
    lcd_q.push_back('{rs: 1'b0, data: LCD_FUNC_SET, wait_len: 5});
    lcd_q.push_back('{rs: 1'b0, data: LCD_DISP_ON, wait_len: 5});
    lcd_q.push_back('{rs: 1'b0, data: LCD_ENTRY_INC, wait_len: 5});
    lcd_q.push_back('{rs: 1'b0, data: LCD_CLEAR, wait_len: 12});
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    first_chk = 1;
    rst_n = 1'b1;
  endtask

  task automatic send(input int id, input logic rs, input logic [7:0] d);
    bit got;
    got = 0;
    if (id == 0) begin
      req0_valid = 1'b1; req0_rs = rs; req0_data = d;
    end else begin
      req1_valid = 1'b1; req1_rs = rs; req1_data = d;
    end
    for (int i = 0; i < 3000 && !got; i++) begin
      #1;
      if ((id == 0) ? req0_ready : req1_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !lcd_en) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_en(input logic level);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (lcd_en == level) ok = 1;
    end
    if (!ok) chk("en_timeout", 0, 1);
  endtask

  int rise0, rdy0;

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
    // Scenarios 1+2: init sequence, with req0 already waiting from reset
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h46;
    repeat (3) @(negedge clk);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);
    push_init();
    lcd_q.push_back('{rs: 1'b1, data: 8'h46, wait_len: 5});
    gnt_q.push_back('{id: 0, spacing: 0});
    release_reset();
    send(0, 1'b1, 8'h46);
    wait_idle();

    // Scenario 4: long wait for clear, short for data 0x01
    gnt_q.push_back('{id: 1, spacing: 0});
    lcd_q.push_back('{rs: 1'b0, data: 8'h01, wait_len: 12});
    gnt_q.push_back('{id: 1, spacing: 0});
    lcd_q.push_back('{rs: 1'b1, data: 8'h01, wait_len: 5});
    send(1, 1'b0, 8'h01);
    send(1, 1'b1, 8'h01);
    wait_idle();

    // Scenario 3: both continuously valid, alternation and spacing
    gnt_q.push_back('{id: 0, spacing: 0});
    gnt_q.push_back('{id: 1, spacing: 11});
    gnt_q.push_back('{id: 0, spacing: 11});
    gnt_q.push_back('{id: 1, spacing: 11});
    lcd_q.push_back('{rs: 1'b1, data: 8'h41, wait_len: 5});
    lcd_q.push_back('{rs: 1'b0, data: LCD_LINE2, wait_len: 5});
    lcd_q.push_back('{rs: 1'b1, data: 8'h42, wait_len: 5});
    lcd_q.push_back('{rs: 1'b1, data: 8'h43, wait_len: 5});
    fork
      begin send(0, 1'b1, 8'h41); send(0, 1'b1, 8'h42); end
      begin send(1, 1'b0, LCD_LINE2); send(1, 1'b1, 8'h43); end
    join

    // Scenario 6: request withdrawn while the device is still in WAIT
    wait_en(1'b1);
    wait_en(1'b0);
    rise0 = tot_rise;
    rdy0 = tot_rdy;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h99;
    repeat (2) @(negedge clk);
    req0_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("withdrawn_no_ready", tot_rdy - rdy0, 0);
    chk("withdrawn_no_en", tot_rise - rise0, 0);

    // Scenario 5: reset during EN_HI of a user write
    gnt_q.push_back('{id: 0, spacing: 0});
    lcd_q.push_back('{rs: 1'b1, data: 8'h55, wait_len: 5});
    send(0, 1'b1, 8'h55);
    wait_en(1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_en", int'(lcd_en), 0);
    chk("abort_data", int'(lcd_data), 0);
    chk("abort_init_done", int'(init_done), 0);
    chk("abort_busy", int'(busy), 1);
    repeat (3) @(negedge clk);
    push_init();
    release_reset();
    wait_idle();
    chk("reinit_done", int'(init_done), 1);
    repeat (5) @(negedge clk);
    chk("lcd_q_drained", lcd_q.size(), 0);
    chk("gnt_q_drained", gnt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
